// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency data BRAM between the CPU data
// port (0) and a secondary master (1); one latched transaction at a time.
module dmem_arbiter #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req0,
    input  logic                  i_we0,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [XLEN-1:0]       i_data0,
    input  logic                  i_req1,
    input  logic                  i_we1,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [XLEN-1:0]       i_data1,
    output logic                  o_valid0,
    output logic [XLEN-1:0]       o_data0,
    output logic                  o_valid1,
    output logic [XLEN-1:0]       o_data1,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [XLEN-1:0]       o_mem_data,
    input  logic [XLEN-1:0]       i_mem_q,
    output logic                  o_busy,
    output logic [1:0]            o_gnt
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state, state_nxt;
    logic                  last;
    logic                  grant_id;
    logic                  take;
    logic                  lat_we;
    logic                  lat_id;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [XLEN-1:0]       lat_data;

    // Under contention the port not granted last time wins; otherwise the sole requester.
    assign grant_id = (i_req0 && i_req1) ? ~last : ~i_req0;

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        o_mem_we  = 1'b0;
        o_valid0  = 1'b0;
        o_valid1  = 1'b0;
        o_busy    = 1'b0;
        o_gnt     = 2'b00;
        case (state)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    take      = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                o_busy    = 1'b1;
                o_gnt     = lat_id ? 2'b10 : 2'b01;
                o_mem_we  = lat_we & ~i_rst;
                state_nxt = RESP;
            end
            RESP: begin
                o_busy    = 1'b1;
                o_gnt     = lat_id ? 2'b10 : 2'b01;
                o_valid0  = ~lat_id & ~i_rst;
                o_valid1  = lat_id & ~i_rst;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            lat_we   <= 1'b0;
            lat_id   <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                last     <= grant_id;
                lat_id   <= grant_id;
                lat_we   <= grant_id ? i_we1   : i_we0;
                lat_addr <= grant_id ? i_addr1 : i_addr0;
                lat_data <= grant_id ? i_data1 : i_data0;
            end
        end
    end

    // The latched copies only change on a new grant, so the memory bus holds outside ACCESS.
    assign o_mem_addr = lat_addr;
    assign o_mem_data = lat_data;
    assign o_data0    = o_valid0 ? i_mem_q : '0;
    assign o_data1    = o_valid1 ? i_mem_q : '0;

endmodule
